// File: rtl/fetch_unit.sv
// fetch_unit: PC register and IDLE/FETCH/VALID fetch FSM with ack timeout and IR decode fields
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        pc_upd,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] npc_t,
  output logic [31:0] instr,
  output logic [25:0] instr_index,
  output logic [31:0] offset,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic        addr_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state;
  logic [7:0] cnt;
  logic upd_ok;
  assign upd_ok = pc_upd && npc[1:0] == 2'b00;
  assign imem_addr = pc;
  assign npc_t = pc + 32'd4;
  assign instr_index = instr[25:0];
  assign offset = {{16{instr[15]}}, instr[15:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= 32'd0;
      cnt <= 8'd0;
      imem_req <= 1'b0;
      ir_valid <= 1'b0;
      fetch_err <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (state == FETCH) begin
        if (imem_ack) begin
          instr <= imem_rdata;
          cnt <= 8'd0;
          state <= VALID;
          imem_req <= 1'b0;
          ir_valid <= 1'b1;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          fetch_err <= 1'b1;
          cnt <= 8'd0;
          state <= IDLE;
          imem_req <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        if (upd_ok) pc <= npc;
        if (pc_upd && !upd_ok) addr_err <= 1'b1;
        if (fetch_go) begin
          state <= FETCH;
          imem_req <= 1'b1;
          ir_valid <= 1'b0;
        end else if (upd_ok) begin
          state <= IDLE;
          ir_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, fetch_go, pc_upd, imem_ack;
  logic [31:0] npc, imem_rdata;
  logic imem_req, ir_valid, fetch_err, addr_err;
  logic [31:0] imem_addr, pc, npc_t, instr, offset;
  logic [25:0] instr_index;
  int checks = 0;
  int errors = 0;
  int reqs, errs;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_upd(pc_upd), .npc(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .npc_t(npc_t), .instr(instr), .instr_index(instr_index), .offset(offset),
    .ir_valid(ir_valid), .fetch_err(fetch_err), .addr_err(addr_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; fetch_go = 1'b0; pc_upd = 1'b0; imem_ack = 1'b0; npc = 32'd0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_irv", 32'(ir_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_ferr", 32'(fetch_err), 32'd0);
    chk("rst_aerr", 32'(addr_err), 32'd0);
    chk("rst_npct", npc_t, 32'h0000_3004);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    chk("f1_req", 32'(imem_req), 32'd1);
    chk("f1_addr", imem_addr, 32'h0000_3000);
    chk("f1_irv", 32'(ir_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1000_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("f1_valid", 32'(ir_valid), 32'd1);
    chk("f1_req_off", 32'(imem_req), 32'd0);
    chk("f1_instr", instr, 32'h1000_FFFF);
    chk("f1_offset", offset, 32'hFFFF_FFFF);
    chk("f1_index", 32'(instr_index), 32'h000_FFFF);
    chk("f1_npct", npc_t, 32'h0000_3004);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    reqs = 0; errs = 0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req) reqs++;
      if (fetch_err) errs++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(reqs), 32'd16);
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_req_off", 32'(imem_req), 32'd0);
    chk("to_irv", 32'(ir_valid), 32'd0);
    chk("to_pc", pc, 32'h0000_3000);
    chk("to_instr", instr, 32'h1000_FFFF);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_8000;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("f2_valid", 32'(ir_valid), 32'd1);
    chk("f2_offset", offset, 32'hFFFF_8000);
    chk("f2_index", 32'(instr_index), 32'h000_8000);
    pc_upd = 1'b1; fetch_go = 1'b1; npc = 32'h0000_3040;
    @(negedge clk);
    chk("ug_pc", pc, 32'h0000_3040);
    chk("ug_req", 32'(imem_req), 32'd1);
    chk("ug_addr", imem_addr, 32'h0000_3040);
    chk("ug_irv", 32'(ir_valid), 32'd0);
    npc = 32'h0000_5000;
    @(negedge clk);
    pc_upd = 1'b0; fetch_go = 1'b0;
    chk("fu_pc", pc, 32'h0000_3040);
    chk("fu_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("fu_pc_after", pc, 32'h0000_3040);
    chk("fu_valid", 32'(ir_valid), 32'd1);
    chk("fu_offset", offset, 32'h0000_5678);
    chk("fu_index", 32'(instr_index), 32'h234_5678);
    pc_upd = 1'b1; npc = 32'h0000_3100;
    @(negedge clk);
    chk("uv_pc", pc, 32'h0000_3100);
    chk("uv_irv", 32'(ir_valid), 32'd0);
    chk("uv_req", 32'(imem_req), 32'd0);
    npc = 32'h0000_3042;
    @(negedge clk);
    chk("mis_pc", pc, 32'h0000_3100);
    chk("mis_aerr", 32'(addr_err), 32'd1);
    npc = 32'h0000_3200;
    @(negedge clk);
    chk("sticky_pc", pc, 32'h0000_3200);
    chk("sticky_aerr", 32'(addr_err), 32'd1);
    npc = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_upd = 1'b0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_npct", npc_t, 32'h0000_0000);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_instr", instr, 32'h1234_5678);
    chk("idle_ack_irv", 32'(ir_valid), 32'd0);
    fetch_go = 1'b1;
    @(negedge clk);
    chk("rf_req", 32'(imem_req), 32'd1);
    rst = 1'b1; pc_upd = 1'b1; npc = 32'h0000_4000;
    @(negedge clk);
    rst = 1'b0; fetch_go = 1'b0; pc_upd = 1'b0;
    chk("rf_req_off", 32'(imem_req), 32'd0);
    chk("rf_pc", pc, 32'h0000_3000);
    chk("rf_aerr", 32'(addr_err), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_req", 32'(imem_req), 32'd0);
    chk("late_instr", instr, 32'd0);
    chk("late_irv", 32'(ir_valid), 32'd0);
    chk("late_pc", pc, 32'h0000_3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
